// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//
// Purpose: collects a message of up to MAX_WORDS 32-bit words from a
// valid/ready word source and lays it out as one or more 512-bit SHA-256
// blocks. Each block carries the 0x80000000 marker word after the data and a
// 64-bit bit-length field in the last two words of the final block. Every
// block is handed to the SHA-256 core with a one-cycle blk_start pulse. The
// padder then waits for the core's done level to fall and rise again before
// it builds the next block.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   start        request to pad one message (accepted only in IDLE)
//   msg_len      message length in words, sampled with start (0..MAX_WORDS)
//   word_valid   source presents word_data
//   word_data    message word, big-endian word order
//   word_ready   padder accepts word_data this cycle
//   blk_message  padded block, blk_message[i] is message word i
//   blk_start    one-cycle pulse, blk_message is valid
//   blk_first    current block is block 0 of the message
//   blk_last     current block is the final block of the message
//   blk_done     SHA-256 core done level, high when the core is idle
//   busy         high from accepted start until return to IDLE
//   all_done     one-cycle pulse after the final block completes
module sha256_msg_padder #(
  parameter int MAX_WORDS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        msg_len,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  output logic [15:0][31:0] blk_message,
  output logic              blk_start,
  output logic              blk_first,
  output logic              blk_last,
  input  logic              blk_done,
  output logic              busy,
  output logic              all_done
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [7:0]        blk_idx_q, blk_idx_d;
  logic [4:0]        slot_q, slot_d;
  logic [15:0][31:0] msg_q, msg_d;
  logic              busy_q, busy_d;
  logic              first_q, first_d;
  logic              last_q, last_d;

  logic [7:0]        nblk;
  logic              final_blk;
  logic              accept;
  logic [11:0]       pos;

  // One marker word plus a two-word length field follow the data, so the
  // message needs ceil((msg_len+3)/16) = (msg_len+18)/16 blocks.
  assign nblk      = 8'(({1'b0, len_q} + 9'd18) / 9'd16);
  assign final_blk = (blk_idx_q == (nblk - 8'd1));

  assign word_ready  = (state_q == FILL) && (slot_q < 5'd16) && (wcnt_q < len_q);
  assign accept      = word_ready && word_valid;

  assign blk_message = msg_q;
  assign blk_first   = first_q;
  assign blk_last    = last_q;
  assign busy        = busy_q;

  // Next-state and datapath updates for the whole padder.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    blk_idx_d = blk_idx_q;
    slot_d    = slot_q;
    msg_d     = msg_q;
    busy_d    = busy_q;
    first_d   = first_q;
    last_d    = last_q;
    blk_start = 1'b0;
    all_done  = 1'b0;
    pos       = 12'd0;

    case (state_q)
      IDLE: begin
        if (start && (msg_len <= MAX_LEN)) begin
          len_d     = msg_len;
          wcnt_d    = 8'd0;
          slot_d    = 5'd0;
          blk_idx_d = 8'd0;
          busy_d    = 1'b1;
          state_d   = FILL;
        end
      end

      FILL: begin
        if (accept) begin
          msg_d[slot_q[3:0]] = word_data;
          slot_d             = slot_q + 5'd1;
          wcnt_d             = wcnt_q + 8'd1;
        end
        // Leave on the edge that takes the last word of this block, so that
        // PAD and ISSUE follow in the next two cycles.
        if (!word_ready ||
            (accept && ((slot_q == 5'd15) || ((wcnt_q + 8'd1) == len_q)))) begin
          state_d = PAD;
        end
      end

      PAD: begin
        // Slots at or above the current slot index hold no data for this
        // block; fill them from the global word position.
        for (int i = 0; i < 16; i++) begin
          if (5'(i) >= slot_q) begin
            pos = {blk_idx_q, 4'b0000} + 12'(i);
            if (pos == {4'b0000, len_q}) begin
              msg_d[i] = 32'h8000_0000;
            end else if (final_blk && (i == 15)) begin
              msg_d[i] = {19'd0, len_q, 5'd0};
            end else begin
              msg_d[i] = 32'h0000_0000;
            end
          end
        end
        first_d = (blk_idx_q == 8'd0);
        last_d  = final_blk;
        state_d = ISSUE;
      end

      ISSUE: begin
        blk_start = 1'b1;
        state_d   = WAIT_LO;
      end

      WAIT_LO: begin
        if (!blk_done) begin
          state_d = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (blk_done) begin
          if (!final_blk) begin
            blk_idx_d = blk_idx_q + 8'd1;
            slot_d    = 5'd0;
            state_d   = FILL;
          end else begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        all_done = 1'b1;
        busy_d   = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= 8'd0;
      wcnt_q    <= 8'd0;
      blk_idx_q <= 8'd0;
      slot_q    <= 5'd0;
      msg_q     <= '0;
      busy_q    <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      blk_idx_q <= blk_idx_d;
      slot_q    <= slot_d;
      msg_q     <= msg_d;
      busy_q    <= busy_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

endmodule
